// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, fetches over a req/ack
// handshake with wait states, applies ID redirects/stalls. Optional: PIPE_IF_MISALIGN_EN.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] d_inst,
  output logic [31:0] d_pc4,
  output logic        d_valid,
  output logic        if_misalign
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic [XLEN-1:0]   rtgt_q, rtgt_d;
  logic [XLEN-1:0]   d_inst_q, d_inst_d;
  logic [XLEN-1:0]   d_pc4_q, d_pc4_d;
  logic              d_valid_q, d_valid_d;
  logic              req_q, req_d;
  logic              mis_q, mis_d;

  logic [XLEN-1:0]   pc4;
  logic [XLEN-1:0]   target_raw;
  logic [XLEN-1:0]   target;
  logic              redirect;

  // Next-state, PC, and IF/ID update; a redirect always bubbles the IF/ID register.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    rtgt_d    = rtgt_q;
    d_inst_d  = d_inst_q;
    d_pc4_d   = d_pc4_q;
    d_valid_d = d_valid_q;
    mis_d     = mis_q;

    pc4      = pc_q + XLEN'(4);
    redirect = d_valid_q & wpcir & (pcsource != 2'b00);
    case (pcsource)
      2'b01:   target_raw = bpc;
      2'b10:   target_raw = rpc;
      2'b11:   target_raw = jpc;
      default: target_raw = pc4;
    endcase
    target = target_raw & ~XLEN'(3);

    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          d_inst_d = '0; d_pc4_d = '0; d_valid_d = 1'b0;
          if (imem_ack) begin
            pc_d = target;
          end else begin
            rtgt_d  = target;
            state_d = S_DRAIN;
          end
        end else if (imem_ack && wpcir) begin
          d_inst_d = imem_rdata; d_pc4_d = pc4; d_valid_d = 1'b1;
          pc_d     = pc4;
        end else if (imem_ack) begin
          buf_d   = imem_rdata;
          state_d = S_HOLD;
        end else if (wpcir) begin
          d_inst_d = '0; d_pc4_d = '0; d_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          d_inst_d = '0; d_pc4_d = '0; d_valid_d = 1'b0;
          pc_d     = target;
          state_d  = S_FETCH;
        end else if (wpcir) begin
          d_inst_d = buf_q; d_pc4_d = pc4; d_valid_d = 1'b1;
          pc_d     = pc4;
          state_d  = S_FETCH;
        end
      end
      S_DRAIN: begin
        // In-flight word at the old PC is dropped; the saved target takes over on ack.
        if (wpcir) begin
          d_inst_d = '0; d_pc4_d = '0; d_valid_d = 1'b0;
        end
        if (imem_ack) begin
          pc_d    = rtgt_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

`ifdef PIPE_IF_MISALIGN_EN
    if (redirect && (target_raw[1:0] != 2'b00)) mis_d = 1'b1;
`else
    mis_d = 1'b0;
`endif

    req_d = (state_d != S_HOLD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      buf_q     <= '0;
      rtgt_q    <= '0;
      d_inst_q  <= '0;
      d_pc4_q   <= '0;
      d_valid_q <= 1'b0;
      req_q     <= 1'b1;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_q     <= buf_d;
      rtgt_q    <= rtgt_d;
      d_inst_q  <= d_inst_d;
      d_pc4_q   <= d_pc4_d;
      d_valid_q <= d_valid_d;
      req_q     <= req_d;
      mis_q     <= mis_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign d_inst      = d_inst_q;
  assign d_pc4       = d_pc4_q;
  assign d_valid     = d_valid_q;
  assign if_misalign = mis_q;

endmodule

// File: doc/pipe_if_stage.md
# pipe_if_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipelined CPU, sitting directly upstream of the ID-stage control unit. It owns the PC and issues fetches to instruction memory over a req/ack handshake that tolerates wait states. It applies the next-PC selection (`pcsource`) and stall (`wpcir`) produced in ID, and presents `d_inst`/`d_pc4` to ID. Any redirect squashes the sequentially fetched instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clock`  in  1: single clock, all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `pcsource`  in  2: from ID; 00 = pc+4, 01 = `bpc`, 10 = `rpc`, 11 = `jpc`.
- `bpc`  in  32: branch target from ID.
- `rpc`  in  32: jr register target from ID.
- `jpc`  in  32: jump/jal target from ID.
- `wpcir`  in  1: 1 = ID advances this cycle; 0 = ID stalled (load-use hazard).
- `imem_rdata`  in  32: instruction word, valid when `imem_ack`=1.
- `imem_ack`  in  1: fetch complete this cycle.
- `imem_req`  out  1: fetch request; `imem_addr` held stable while high until ack.
- `imem_addr`  out  32: fetch address (= PC register).
- `d_inst`  out  32: IF/ID instruction; 32'h0 (sll $0,$0,0) on bubble.
- `d_pc4`  out  32: IF/ID pc+4 of `d_inst`; 0 on bubble.
- `d_valid`  out  1: IF/ID holds a real instruction.
- `if_misalign`  out  1: sticky misaligned-target flag (see Configuration).

## Operation
- States: FETCH (req=1), HOLD (req=0, word buffered, ID stalled), DRAIN (req=1, in-flight fetch to be discarded).
- redirect = `d_valid` & `wpcir` & (`pcsource` != 00); target per `pcsource`, target[1:0] forced to 00.
- deliver = load IF/ID with {`pc`+4, word, valid=1}; bubble = load IF/ID with {0, 0, valid=0}.
- `wpcir`=0: IF/ID unchanged, `pcsource` ignored.
- FETCH:
  - redirect & ack: bubble; pc←target; stay FETCH (word discarded).
  - redirect & !ack: bubble; rtgt←target; → DRAIN.
  - ack & `wpcir`: deliver `imem_rdata`; pc←pc+4.
  - ack & !`wpcir`: buf←`imem_rdata`; → HOLD (pc unchanged).
  - !ack & `wpcir`: bubble.
- HOLD:
  - redirect: bubble; buf discarded; pc←target; → FETCH.
  - `wpcir`: deliver buf; pc←pc+4; → FETCH.
- DRAIN: `imem_addr` stays old pc; bubble whenever `wpcir`=1; on ack: pc←rtgt, word discarded, → FETCH.
- No redirect can occur in DRAIN: the redirect cycle always leaves `d_valid`=0.
- pc+4 wraps modulo 2^32.

## Timing
- Reset: state FETCH, pc=`RESET_PC`, `d_valid`=0, `d_inst`=0, `d_pc4`=0, buf=0, rtgt=0, `if_misalign`=0; `imem_req`=1 in the first cycle after reset.
- Reset mid-DRAIN/HOLD abandons the in-flight fetch or buffered word; imem shares reset.
- `imem_req` and `imem_addr` are decoded from state/pc registers only, with no input-to-output combinational path.
- Zero-wait memory (ack same cycle as req): one instruction per cycle; `d_inst` is valid the cycle after ack.
- Taken redirect penalty: 1 bubble with zero-wait memory; plus the remaining DRAIN wait cycles otherwise.
- Simultaneous ack, `wpcir`=0 and a valid `pcsource`: `pcsource` is ignored, and the word goes to HOLD.

## Configuration
- `PIPE_IF_MISALIGN_EN` defined: on redirect with target[1:0] != 00, set `if_misalign`←1; it is cleared only by reset. Target is still forced-aligned.
- Undefined: `if_misalign` is tied to 0; low target bits are silently forced to 00.

## Test plan
- Reset with `RESET_PC`=32'h100, zero-wait imem, `wpcir`=1, `pcsource`=00 -> `imem_addr` 100,104,108 on consecutive cycles; `d_pc4` 104,108,10C one cycle behind, `d_valid`=1.
- Ack at pc=104 with `wpcir`=0 for 3 cycles -> HOLD, `imem_req`=0, IF/ID unchanged; when `wpcir`=1, `d_inst`=word@104 and `imem_addr`=108 the next cycle.
- `d_valid`=1, `pcsource`=01, `bpc`=32'h200, ack same cycle -> next cycle `d_valid`=0, `imem_addr`=200; word@200 appears the following cycle.
- Redirect `pcsource`=11, `jpc`=32'h300 while fetch at 108 has 2 wait states -> `imem_addr` stays 108 until ack, word@108 is never delivered, then `imem_addr`=300.
- `pcsource`=10, `rpc`=32'h402 with macro defined -> `imem_addr`=400, `if_misalign`=1 and sticky until reset; with macro undefined -> `if_misalign`=0.
- Reset asserted during DRAIN -> next cycle state FETCH, `imem_addr`=`RESET_PC`, `d_valid`=0.
